sdram_acc_sched: RTL and testbench

SDRAM_ACC_SCHED -- requirements
Module: sdram_acc_sched

---
 rtl/sdram_acc_sched_if.sv | 30 +++
 rtl/sdram_acc_sched.sv | 149 ++++++++++++++
 tb/tb_sdram_acc_sched.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_acc_sched_if.sv
// Request/command bundle between the QSPI front-end, the write-back requester,
// the access scheduler and the SDRAM controller.
interface sdram_acc_sched_if;
  logic        qspi_rd_req;
  logic [23:0] qspi_rd_addr;
  logic        qspi_rd_busy;
  logic        forbiden_autofresh;
  logic        wr_req;
  logic [23:0] wr_addr;
  logic        wr_ack;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [23:0] cmd_addr;
  logic        cmd_ready;
  logic        cmd_done;
  logic        rd_overrun;
  logic [3:0]  ref_debt;

  modport slave (
    input  qspi_rd_req, qspi_rd_addr, forbiden_autofresh, wr_req, wr_addr,
           cmd_ready, cmd_done,
    output qspi_rd_busy, wr_ack, cmd_valid, cmd_op, cmd_addr, rd_overrun, ref_debt
  );

  modport master (
    output qspi_rd_req, qspi_rd_addr, forbiden_autofresh, wr_req, wr_addr,
           cmd_ready, cmd_done,
    input  qspi_rd_busy, wr_ack, cmd_valid, cmd_op, cmd_addr, rd_overrun, ref_debt
  );
endinterface

// File: rtl/sdram_acc_sched.sv
// SDRAM access scheduler: arbitrates QSPI line reads, write-back bursts and
// auto-refresh, keeping exactly one command outstanding at the controller.
module sdram_acc_sched #(
  parameter int REF_INTERVAL = 624,
  parameter int MAX_DEBT     = 8
) (
  input  logic             fast_clk,
  input  logic             rst,
  sdram_acc_sched_if.slave bus
);

  localparam int          TW         = ($clog2(REF_INTERVAL) > 0) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(REF_INTERVAL - 1);
  localparam logic [3:0]  DEBT_MAX   = 4'(MAX_DEBT);
  localparam logic [1:0]  OP_RD      = 2'b00;
  localparam logic [1:0]  OP_WR      = 2'b01;
  localparam logic [1:0]  OP_REF     = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_debt;
  logic          r_rd_pend;
  logic [23:0]   r_rd_addr;
  logic          r_overrun;
  logic          r_cmd_valid;
  logic [1:0]    r_cmd_op;
  logic [23:0]   r_cmd_addr;

  logic          w_tick;
  logic          w_accept;
  logic          w_ref_acc;
  logic          w_rd_acc;
  logic          w_grant;
  logic [1:0]    w_grant_op;
  logic [23:0]   w_grant_addr;

  assign w_tick    = (r_timer == TIMER_LAST);
  assign w_accept  = (r_state == S_ISSUE) && bus.cmd_ready;
  assign w_ref_acc = w_accept && (r_cmd_op == OP_REF);
  assign w_rd_acc  = w_accept && (r_cmd_op == OP_RD);

  // Refresh interval timer; the wrap cycle is the refresh tick.
  always_ff @(posedge fast_clk) begin
    if (rst)         r_timer <= '0;
    else if (w_tick) r_timer <= '0;
    else             r_timer <= r_timer + TW'(1);
  end

  // Refresh debt: ticks add (saturating), accepted refreshes subtract.
  always_ff @(posedge fast_clk) begin
    if (rst) begin
      r_debt <= 4'd0;
    end else if (w_tick && !w_ref_acc) begin
      if (r_debt != DEBT_MAX) r_debt <= r_debt + 4'd1;
    end else if (!w_tick && w_ref_acc) begin
      r_debt <= r_debt - 4'd1;
    end
  end

  // Read latch; a fresh request beats the clear from an acceptance in the same cycle.
  always_ff @(posedge fast_clk) begin
    if (rst) begin
      r_rd_pend <= 1'b0;
      r_rd_addr <= 24'd0;
      r_overrun <= 1'b0;
    end else if (bus.qspi_rd_req) begin
      r_rd_pend <= 1'b1;
      r_rd_addr <= bus.qspi_rd_addr;
      if (r_rd_pend && !w_rd_acc) r_overrun <= 1'b1;
    end else if (w_rd_acc) begin
      r_rd_pend <= 1'b0;
    end
  end

  // Grant selection; a read arriving this cycle holds off lower priorities
  // so it is served once it reaches the latch.
  always_comb begin
    w_grant      = 1'b0;
    w_grant_op   = OP_RD;
    w_grant_addr = 24'd0;
    if (r_debt == DEBT_MAX) begin
      w_grant    = 1'b1;
      w_grant_op = OP_REF;
    end else if (r_rd_pend) begin
      w_grant      = 1'b1;
      w_grant_addr = r_rd_addr;
    end else if (bus.qspi_rd_req) begin
      w_grant = 1'b0;
    end else if ((r_debt != 4'd0) && !bus.forbiden_autofresh) begin
      w_grant    = 1'b1;
      w_grant_op = OP_REF;
    end else if (bus.wr_req) begin
      w_grant      = 1'b1;
      w_grant_op   = OP_WR;
      w_grant_addr = bus.wr_addr;
    end else begin
      w_grant = 1'b0;
    end
  end

  // Command FSM with registered command outputs.
  always_ff @(posedge fast_clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= OP_RD;
      r_cmd_addr  <= 24'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state     <= S_ISSUE;
            r_cmd_valid <= 1'b1;
            r_cmd_op    <= w_grant_op;
            r_cmd_addr  <= w_grant_addr;
          end
        end
        S_ISSUE: begin
          if (bus.cmd_ready) begin
            r_state     <= S_WAIT;
            r_cmd_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.cmd_done) r_state <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_valid    = r_cmd_valid;
  assign bus.cmd_op       = r_cmd_op;
  assign bus.cmd_addr     = r_cmd_addr;
  assign bus.wr_ack       = w_accept && (r_cmd_op == OP_WR);
  assign bus.qspi_rd_busy = r_rd_pend || ((r_state != S_IDLE) && (r_cmd_op == OP_RD));
  assign bus.rd_overrun   = r_overrun;
  assign bus.ref_debt     = r_debt;

endmodule

// File: tb/tb_sdram_acc_sched.sv
// Bench for sdram_acc_sched: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level scheduler model.
module tb_sdram_acc_sched;
  localparam int RI = 16;
  localparam int MD = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_acc_sched_if bus();

  sdram_acc_sched #(.REF_INTERVAL(RI), .MAX_DEBT(MD)) dut (
    .fast_clk (clk),
    .rst      (rst),
    .bus      (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model: phase 0 = nothing granted, 1 = command offered, 2 = command outstanding.
  int          m_timer, m_debt, m_phase, m_wcnt;
  bit          m_pend, m_ovr;
  logic [23:0] m_paddr, m_addr;
  logic [1:0]  m_op;

  int          ready_mode = 0;
  int          done_dly   = 3;
  bit          spur_en    = 1'b0;
  bit          wr_drop    = 1'b0;
  int          ack_cnt    = 0;
  logic        prev_valid = 1'b0;
  logic [1:0]  grant_ops[$];
  logic [23:0] grant_addrs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_timer = 0; m_debt = 0; m_phase = 0; m_wcnt = 0;
    m_pend = 1'b0; m_ovr = 1'b0; m_paddr = 24'd0; m_addr = 24'd0; m_op = 2'b00;
  endtask

  task automatic grant(input logic [1:0] op, input logic [23:0] a);
    m_phase = 1; m_op = op; m_addr = a;
  endtask

  // Controller side of the bus, reacting to the model's view of the command.
  task automatic drive_ctrl();
    case (ready_mode)
      0:       bus.cmd_ready = 1'b1;
      1:       bus.cmd_ready = (($urandom % 4) != 0);
      default: bus.cmd_ready = 1'b0;
    endcase
    bus.cmd_done = (m_phase == 2) && (m_wcnt >= done_dly - 1);
    if (spur_en && (m_phase != 2) && (($urandom % 16) == 0)) bus.cmd_done = 1'b1;
  endtask

  task automatic compare();
    bit e_valid, e_ack, e_busy;
    e_valid = (m_phase == 1);
    e_ack   = e_valid && (m_op == 2'b01) && bus.cmd_ready;
    e_busy  = m_pend || ((m_phase != 0) && (m_op == 2'b00));
    chk("cmd_valid", bus.cmd_valid, e_valid);
    if (e_valid) begin
      chk("cmd_op", bus.cmd_op, m_op);
      chk("cmd_addr", bus.cmd_addr, m_addr);
    end
    chk("wr_ack", bus.wr_ack, e_ack);
    chk("qspi_rd_busy", bus.qspi_rd_busy, e_busy);
    chk("rd_overrun", bus.rd_overrun, m_ovr);
    chk("ref_debt", bus.ref_debt, m_debt);
    if (bus.wr_ack) ack_cnt++;
    if (bus.cmd_valid && !prev_valid) begin
      grant_ops.push_back(bus.cmd_op);
      grant_addrs.push_back(bus.cmd_addr);
    end
    prev_valid = bus.cmd_valid;
  endtask

  task automatic model_step();
    bit acc, tick, opend;
    int odebt;
    logic [23:0] opaddr;
    if (rst) begin
      model_reset();
      wr_drop = 1'b0;
      return;
    end
    acc    = (m_phase == 1) && bus.cmd_ready;
    tick   = (m_timer == RI - 1);
    odebt  = m_debt;
    opend  = m_pend;
    opaddr = m_paddr;
    m_timer = tick ? 0 : m_timer + 1;
    if (tick && !(acc && m_op == 2'b10)) m_debt = (m_debt < MD) ? m_debt + 1 : MD;
    else if (!tick && acc && m_op == 2'b10) m_debt = m_debt - 1;
    if (bus.qspi_rd_req) begin
      if (m_pend && !(acc && m_op == 2'b00)) m_ovr = 1'b1;
      m_pend  = 1'b1;
      m_paddr = bus.qspi_rd_addr;
    end else if (acc && m_op == 2'b00) begin
      m_pend = 1'b0;
    end
    wr_drop = acc && (m_op == 2'b01);
    case (m_phase)
      0: begin
        if (odebt == MD) grant(2'b10, 24'd0);
        else if (opend) grant(2'b00, opaddr);
        else if (bus.qspi_rd_req) begin end
        else if (odebt > 0 && !bus.forbiden_autofresh) grant(2'b10, 24'd0);
        else if (bus.wr_req) grant(2'b01, bus.wr_addr);
      end
      1: if (bus.cmd_ready) begin m_phase = 2; m_wcnt = 0; end
      2: if (bus.cmd_done) m_phase = 0; else m_wcnt++;
      default: m_phase = 0;
    endcase
  endtask

  task automatic cycle();
    drive_ctrl();
    #2;
    compare();
    model_step();
    @(posedge clk);
    #1;
    if (wr_drop) bus.wr_req = 1'b0;
  endtask

  task automatic wait_phase(input int ph, input int lim, input string nm);
    int k = 0;
    while (m_phase != ph && k < lim) begin cycle(); k++; end
    if (k >= lim) begin
      n_chk++;
      $display("FAIL %s: timeout after %0d cycles, phase %0d required %0d", nm, k, m_phase, ph);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nref, maxd;
    bit seen0;
    rst = 1'b1;
    bus.qspi_rd_req = 1'b0; bus.qspi_rd_addr = 24'd0; bus.forbiden_autofresh = 1'b0;
    bus.wr_req = 1'b0; bus.wr_addr = 24'd0; bus.cmd_ready = 1'b0; bus.cmd_done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    repeat (2) cycle();
    rst = 1'b0;
    chk("reset_valid", bus.cmd_valid, 1'b0);
    chk("reset_debt", bus.ref_debt, 4'd0);
    chk("reset_busy", bus.qspi_rd_busy, 1'b0);
    chk("reset_addr", bus.cmd_addr, 24'd0);

    // Read latency and busy window.
    bus.qspi_rd_addr = 24'h001230; bus.qspi_rd_req = 1'b1;
    cycle();
    bus.qspi_rd_req = 1'b0;
    chk("rd_busy_latched", bus.qspi_rd_busy, 1'b1);
    chk("rd_not_yet_valid", bus.cmd_valid, 1'b0);
    cycle();
    chk("rd_valid", bus.cmd_valid, 1'b1);
    chk("rd_op", bus.cmd_op, 2'b00);
    chk("rd_addr", bus.cmd_addr, 24'h001230);
    for (int i = 0; i < 3; i++) begin cycle(); chk("rd_busy_wait", bus.qspi_rd_busy, 1'b1); end
    cycle();
    chk("rd_busy_drop", bus.qspi_rd_busy, 1'b0);

    // Periodic refresh with no other traffic.
    repeat (20) cycle();
    nref = 0; maxd = 0;
    for (int i = 0; i < 160; i++) begin
      cycle();
      if (bus.cmd_valid && bus.cmd_op == 2'b10) nref++;
      if (int'(bus.ref_debt) > maxd) maxd = int'(bus.ref_debt);
    end
    chk("ref_period_count", nref, 10);
    chk("ref_debt_peak", maxd, 1);

    // Forbid held: debt saturates, urgent refresh overrides, then drains.
    bus.forbiden_autofresh = 1'b1;
    nref = 0; maxd = 0;
    for (int i = 0; i < 20 * RI; i++) begin
      cycle();
      if (bus.cmd_valid && bus.cmd_op == 2'b10) nref++;
      if (int'(bus.ref_debt) > maxd) maxd = int'(bus.ref_debt);
    end
    chk("forbid_debt_peak", maxd, MD);
    chk("urgent_ref_seen", (nref >= 10), 1'b1);
    bus.forbiden_autofresh = 1'b0;
    seen0 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (bus.ref_debt == 4'd0) seen0 = 1'b1;
    end
    chk("debt_drained", seen0, 1'b1);

    // Write and read requested together: read first, one wr_ack.
    bus.forbiden_autofresh = 1'b1;
    wait_phase(0, 50, "idle_before_wr");
    grant_ops.delete(); grant_addrs.delete(); ack_cnt = 0;
    bus.wr_addr = 24'h00ABC0; bus.wr_req = 1'b1;
    bus.qspi_rd_addr = 24'h000450; bus.qspi_rd_req = 1'b1;
    cycle();
    bus.qspi_rd_req = 1'b0;
    repeat (20) cycle();
    chk("rw_grant_count", grant_ops.size(), 2);
    if (grant_ops.size() >= 2) begin
      chk("rw_first_op", grant_ops[0], 2'b00);
      chk("rw_first_addr", grant_addrs[0], 24'h000450);
      chk("rw_second_op", grant_ops[1], 2'b01);
      chk("rw_second_addr", grant_addrs[1], 24'h00ABC0);
    end
    chk("wr_ack_once", ack_cnt, 1);

    // Two reads during WAIT: overrun, one read to the last address.
    done_dly = 8;
    bus.qspi_rd_addr = 24'h000800; bus.qspi_rd_req = 1'b1;
    cycle();
    bus.qspi_rd_req = 1'b0;
    wait_phase(2, 20, "wait_before_overrun");
    bus.qspi_rd_addr = 24'h000100; bus.qspi_rd_req = 1'b1;
    cycle();
    chk("no_overrun_first", bus.rd_overrun, 1'b0);
    bus.qspi_rd_addr = 24'h000200;
    cycle();
    bus.qspi_rd_req = 1'b0;
    chk("overrun_set", bus.rd_overrun, 1'b1);
    grant_ops.delete(); grant_addrs.delete();
    repeat (30) cycle();
    chk("overrun_grants", grant_ops.size(), 1);
    if (grant_ops.size() >= 1) begin
      chk("overrun_op", grant_ops[0], 2'b00);
      chk("overrun_addr", grant_addrs[0], 24'h000200);
    end

    // Stalled ISSUE with toggling inputs, then reset mid-WAIT.
    done_dly = 3;
    wait_phase(0, 50, "idle_before_stall");
    ready_mode = 2;
    bus.wr_addr = 24'h0DEF00; bus.wr_req = 1'b1;
    wait_phase(1, 10, "issue_before_stall");
    for (int i = 0; i < 10; i++) begin
      bus.forbiden_autofresh = ~bus.forbiden_autofresh;
      bus.qspi_rd_req  = ($urandom % 2) == 0;
      bus.qspi_rd_addr = {20'($urandom), 4'h0};
      cycle();
      chk("stall_op", bus.cmd_op, 2'b01);
      chk("stall_addr", bus.cmd_addr, 24'h0DEF00);
    end
    bus.qspi_rd_req = 1'b0;
    ready_mode = 0; done_dly = 8;
    wait_phase(2, 5, "wait_before_reset");
    bus.wr_req = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_valid", bus.cmd_valid, 1'b0);
    chk("mid_rst_busy", bus.qspi_rd_busy, 1'b0);
    chk("mid_rst_overrun", bus.rd_overrun, 1'b0);
    chk("mid_rst_debt", bus.ref_debt, 4'd0);
    chk("mid_rst_op", bus.cmd_op, 2'b00);
    chk("mid_rst_addr", bus.cmd_addr, 24'd0);

    // Randomized traffic against the model.
    ready_mode = 1; spur_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bus.qspi_rd_req = (($urandom % 20) == 0);
      bus.qspi_rd_addr = {20'($urandom), 4'h0};
      if (($urandom % 30) == 0) bus.forbiden_autofresh = ~bus.forbiden_autofresh;
      if (!bus.wr_req && ($urandom % 8) == 0) begin
        bus.wr_req = 1'b1;
        bus.wr_addr = {20'($urandom), 4'h0};
      end else if (bus.wr_req && m_phase == 0 && ($urandom % 40) == 0) begin
        bus.wr_req = 1'b0;
      end
      if (m_phase != 2) done_dly = $urandom_range(1, 4);
      rst = (($urandom % 1000) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
